// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared types and defaults for the GF(2^m) arithmetic blocks.
`default_nettype none

package gf2m_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int         DEF_M    = 7;
  localparam logic [7:0] DEF_POLY = 8'h83;  // x^7 + x + 1

  function automatic int max_cyc(input int m);
    return 4 * m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gf2m_div_x.sv
// gf2m_div_x: combinational g / x mod f for an odd field polynomial f.
`default_nettype none

module gf2m_div_x #(
  parameter int M = 7
) (
  input  logic [M-1:0] g,
  input  logic [M:0]   f,
  output logic [M-1:0] g_out
);

  logic [M:0] sum;
  logic       unused_lsb;

  // Adding f to an odd g clears bit 0, so the shift is exact.
  assign sum        = {1'b0, g} ^ (g[0] ? f : '0);
  assign g_out      = sum[M:1];
  assign unused_lsb = sum[0];

endmodule

`default_nettype wire

// File: rtl/gf2m_inverter.sv
// gf2m_inverter: sequential GF(2^m) inverse via the binary extended Euclidean algorithm.
`default_nettype none

module gf2m_inverter
  import gf2m_pkg::*;
#(
  parameter int M       = DEF_M,
  parameter int MAX_CYC = max_cyc(M)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M:0]   f,
  output logic [M-1:0] c,
  output logic         over,
  output logic         busy,
  output logic         err
);

  localparam int         CW     = $clog2(MAX_CYC);
  localparam logic [M-1:0] ONE_U = M'(1);
  localparam logic [M:0]   ONE_V = (M+1)'(1);

  state_t        state, state_nxt;
  logic [M-1:0]  u, u_nxt, g1, g1_nxt, g2, g2_nxt, c_nxt;
  logic [M:0]    v, v_nxt, f_r, f_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err_nxt;
  logic [M-1:0]  g1_half, g2_half;

  gf2m_div_x #(.M(M)) u_div_g1 (.g(g1), .f(f_r), .g_out(g1_half));
  gf2m_div_x #(.M(M)) u_div_g2 (.g(g2), .f(f_r), .g_out(g2_half));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      u     <= '0;
      v     <= '0;
      f_r   <= '0;
      g1    <= '0;
      g2    <= '0;
      cnt   <= '0;
      c     <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      u     <= u_nxt;
      v     <= v_nxt;
      f_r   <= f_nxt;
      g1    <= g1_nxt;
      g2    <= g2_nxt;
      cnt   <= cnt_nxt;
      c     <= c_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    u_nxt     = u;
    v_nxt     = v;
    f_nxt     = f_r;
    g1_nxt    = g1;
    g2_nxt    = g2;
    cnt_nxt   = cnt;
    c_nxt     = c;
    err_nxt   = err;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          u_nxt     = a;
          v_nxt     = f;
          f_nxt     = f;
          g1_nxt    = ONE_U;
          g2_nxt    = '0;
          cnt_nxt   = '0;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        state_nxt = ST_DONE;
        if (u == '0 || v == '0) begin
          err_nxt = 1'b1;
          c_nxt   = '0;
        end else if (u == ONE_U) begin
          err_nxt = 1'b0;
          c_nxt   = g1;
        end else if (v == ONE_V) begin
          err_nxt = 1'b0;
          c_nxt   = g2;
        end else if (cnt == CW'(MAX_CYC - 1)) begin
          err_nxt = 1'b1;
          c_nxt   = '0;
        end else begin
          state_nxt = ST_RUN;
          cnt_nxt   = cnt + 1'b1;
          if (!u[0]) begin
            u_nxt  = u >> 1;
            g1_nxt = g1_half;
          end else if (!v[0]) begin
            v_nxt  = v >> 1;
            g2_nxt = g2_half;
          end else if ({1'b0, u} >= v) begin
            // v <= u here, so v[M] is zero and the sum stays within M bits
            u_nxt  = u ^ v[M-1:0];
            g1_nxt = g1 ^ g2;
          end else begin
            v_nxt  = v ^ {1'b0, u};
            g2_nxt = g2 ^ g1;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign over = (state == ST_DONE);
  assign busy = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_gf2m_inverter.sv
// tb_gf2m_inverter: randomized self-checking bench against a brute-force field-inverse model.
`default_nettype none

module tb_gf2m_inverter;

  localparam int M       = 7;
  localparam int MAX_CYC = 4 * M;
  localparam int LIM     = MAX_CYC + 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [M-1:0] a;
  logic [M:0]   f;
  logic [M-1:0] c;
  logic         over, busy, err;

  int checks   = 0;
  int failures = 0;

  gf2m_inverter #(.M(M), .MAX_CYC(MAX_CYC)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .f    (f),
    .c    (c),
    .over (over),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y,
                                          input logic [M:0] fp);
    logic [M:0] r;
    r = '0;
    for (int i = M - 1; i >= 0; i--) begin
      r = r << 1;
      if (r[M]) r = r ^ fp;
      if (y[i]) r = r ^ {1'b0, x};
    end
    return r[M-1:0];
  endfunction

  task automatic model_inv(input logic [M-1:0] x, input logic [M:0] fp,
                           output logic [M-1:0] inv, output logic no_inv);
    inv    = '0;
    no_inv = 1'b1;
    for (int k = 1; k < (1 << M); k++) begin
      if (no_inv && gf_mul(x, M'(k), fp) == M'(1)) begin
        inv    = M'(k);
        no_inv = 1'b0;
      end
    end
  endtask

  // Drives one start, optionally keeps start high while busy, returns at the over cycle.
  task automatic do_op(input logic [M-1:0] aa, input logic [M:0] ff, input bit poke,
                       output logic [M-1:0] oc, output logic oerr, output int lat,
                       output bit seen, output bit hs_ok);
    hs_ok = 1'b1;
    @(negedge clk);
    if (busy !== 1'b0 || over !== 1'b0) hs_ok = 1'b0;
    a     = aa;
    f     = ff;
    start = 1'b1;
    lat   = 0;
    seen  = 1'b0;
    while (!seen && lat < LIM) begin
      @(negedge clk);
      lat++;
      if (busy !== 1'b1) hs_ok = 1'b0;
      a     = M'($urandom);
      f     = (M+1)'($urandom);
      start = poke;
      if (over === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    oc    = c;
    oerr  = err;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; a = '0; f = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (c !== '0 || err !== 1'b0 || over !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: c=%h err=%b over=%b busy=%b, want all zero", c, err, over, busy);
    end
    rst = 1'b1;
  endtask

  task automatic test_identity();
    logic [M-1:0] rc; logic re; int lat; bit seen, hs;
    do_op(7'h01, 8'h83, 1'b0, rc, re, lat, seen, hs);
    checks++;
    if (!seen || lat != 2) begin
      failures++; $display("FAIL identity_latency: seen=%b lat=%0d, want 2", seen, lat);
    end
    checks++;
    if (rc !== 7'h01 || re !== 1'b0) begin
      failures++; $display("FAIL identity_value: c=%h err=%b, want 01/0", rc, re);
    end
    checks++;
    if (!hs) begin failures++; $display("FAIL identity_busy: busy/over handshake broken"); end
  endtask

  task automatic test_known();
    logic [M-1:0] rc; logic re; int lat; bit seen, hs;
    logic [M-1:0] ins [2];
    logic [M-1:0] exp [2];
    ins[0] = 7'h02; exp[0] = 7'h41;
    ins[1] = 7'h41; exp[1] = 7'h02;
    for (int i = 0; i < 2; i++) begin
      do_op(ins[i], 8'h83, 1'b0, rc, re, lat, seen, hs);
      checks++;
      if (!seen || rc !== exp[i] || re !== 1'b0 || lat > 30) begin
        failures++;
        $display("FAIL known_inverse a=%h: c=%h err=%b lat=%0d seen=%b, want c=%h err=0 lat<=30",
                 ins[i], rc, re, lat, seen, exp[i]);
      end
    end
  endtask

  task automatic test_zero();
    logic [M-1:0] rc; logic re; int lat; bit seen, hs;
    do_op(7'h00, 8'h83, 1'b0, rc, re, lat, seen, hs);
    checks++;
    if (!seen || rc !== '0 || re !== 1'b1 || lat != 2) begin
      failures++;
      $display("FAIL zero_operand: c=%h err=%b lat=%0d, want c=0 err=1 lat=2", rc, re, lat);
    end
  endtask

  task automatic test_reducible();
    logic [M-1:0] rc; logic re; int lat; bit seen, hs;
    do_op(7'h03, 8'h81, 1'b0, rc, re, lat, seen, hs);
    checks++;
    if (!seen || rc !== '0 || re !== 1'b1 || lat > MAX_CYC + 2) begin
      failures++;
      $display("FAIL reducible_poly: c=%h err=%b lat=%0d seen=%b, want c=0 err=1 lat<=%0d",
               rc, re, lat, seen, MAX_CYC + 2);
    end
  endtask

  task automatic test_exhaustive();
    logic [M-1:0] rc, mc; logic re, me; int lat; bit seen, hs;
    for (int k = 1; k < (1 << M); k++) begin
      do_op(M'(k), 8'h83, bit'(k % 2), rc, re, lat, seen, hs);
      model_inv(M'(k), 8'h83, mc, me);
      checks++;
      if (!seen || rc !== mc || re !== me || gf_mul(M'(k), rc, 8'h83) !== M'(1)
          || lat > MAX_CYC + 2 || !hs) begin
        failures++;
        $display("FAIL exhaustive a=%h: c=%h err=%b lat=%0d hs=%b, want c=%h err=%b",
                 M'(k), rc, re, lat, hs, mc, me);
      end
    end
  endtask

  task automatic test_random_poly();
    logic [M-1:0] rc, mc, ra; logic re, me; logic [M:0] rf; int lat; bit seen, hs;
    for (int n = 0; n < 40; n++) begin
      ra = M'($urandom);
      rf = {1'b1, (M-1)'($urandom), 1'b1};
      do_op(ra, rf, 1'b0, rc, re, lat, seen, hs);
      model_inv(ra, rf, mc, me);
      checks++;
      if (!seen || rc !== mc || re !== me || !hs) begin
        failures++;
        $display("FAIL random_poly a=%h f=%h: c=%h err=%b seen=%b, want c=%h err=%b",
                 ra, rf, rc, re, seen, mc, me);
      end
    end
  endtask

  task automatic test_hold();
    logic [M-1:0] rc; logic re; int lat; bit seen, hs;
    do_op(7'h05, 8'h83, 1'b0, rc, re, lat, seen, hs);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      a = M'($urandom);
      f = (M+1)'($urandom);
      checks++;
      if (c !== rc || err !== re || over !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL result_hold: c=%h err=%b over=%b busy=%b, want c=%h err=%b idle",
                 c, err, over, busy, rc, re);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [M-1:0] rc, mc; logic re, me; int lat; bit seen, hs, stray;
    @(negedge clk);
    a = 7'h55; f = 8'h83; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL mid_run_busy: busy=%b, want 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (c !== '0 || err !== 1'b0 || over !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: c=%h err=%b over=%b busy=%b, want all zero", c, err, over, busy);
    end
    stray = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < LIM; n++) begin
      @(negedge clk);
      if (over === 1'b1) stray = 1'b1;
    end
    checks++;
    if (stray) begin failures++; $display("FAIL reset_no_over: over=1 after abort, want 0"); end
    do_op(7'h55, 8'h83, 1'b0, rc, re, lat, seen, hs);
    model_inv(7'h55, 8'h83, mc, me);
    checks++;
    if (!seen || rc !== mc || re !== me) begin
      failures++;
      $display("FAIL after_reset a=55: c=%h err=%b seen=%b, want c=%h err=%b", rc, re, seen, mc, me);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_known();
    test_zero();
    test_reducible();
    test_exhaustive();
    test_random_poly();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
